int_divider: RTL and testbench

//  Iterative integer divide/remainder unit for the RV M-extension: DIV, DIVU, REM, REMU and the W forms.

---
 rtl/alu_pkg.sv | 15 +
 rtl/int_divider.sv | 164 ++++++++++++++++
 tb/tb_int_divider.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared execute-stage types for the ALU and iterative divider
package alu_pkg;

    typedef enum logic [1:0] {DIV_S, DIV_U, REM_S, REM_U} div_op_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    function automatic logic is_signed_op(input div_op_t op);
        return (op == DIV_S) || (op == REM_S);
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return (op == REM_S) || (op == REM_U);
    endfunction

endpackage

// File: rtl/int_divider.sv
// rtl/int_divider.sv - iterative RV M-extension divide/remainder unit (DIV_EARLY_OUT_EN: special cases skip CALC)
module int_divider
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] d0,
    input  logic [XLEN-1:0] d1,
    input  div_op_t         op,
    input  logic            is_word_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y,
    output logic            busy
);

    localparam int CW    = $clog2(XLEN) + 1;
    localparam int SHIFT = XLEN - 32;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN+31:0] t;
        t = {{XLEN{v[31]}}, v[31:0]};
        return t[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN+31:0] t;
        t = {{XLEN{1'b0}}, v[31:0]};
        return t[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] finalize(
        input div_op_t         f_op,
        input logic            f_word,
        input logic            f_div0,
        input logic            f_ovf,
        input logic            f_negq,
        input logic            f_negr,
        input logic [XLEN-1:0] f_a,
        input logic [XLEN-1:0] f_quo,
        input logic [XLEN-1:0] f_rem
    );
        logic [XLEN-1:0] r;
        if (f_div0)
            r = is_rem_op(f_op) ? f_a : '1;
        else if (f_ovf)
            r = is_rem_op(f_op) ? '0 : f_a;
        else if (is_rem_op(f_op))
            r = f_negr ? -f_rem : f_rem;
        else
            r = f_negq ? -f_quo : f_quo;
        return f_word ? sext32(r) : r;
    endfunction

    div_state_t      state_q;
    div_op_t         op_q;
    logic            word_q, div0_q, ovf_q, negq_q, negr_q, out_valid_q;
    logic [XLEN-1:0] a_ext_q, quo_q, rem_q, b_q, y_q;
    logic [CW-1:0]   cnt_q;

    // Operand preparation for the op being offered on the input side
    logic            sgn, neg_a, neg_b, div0, ovf;
    logic [XLEN-1:0] a_ext, b_ext, min_val, mag_a, mag_b, a_start;

    always_comb begin
        sgn     = is_signed_op(op);
        a_ext   = is_word_op ? (sgn ? sext32(d0) : zext32(d0)) : d0;
        b_ext   = is_word_op ? (sgn ? sext32(d1) : zext32(d1)) : d1;
        min_val = is_word_op ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        neg_a   = sgn && a_ext[XLEN-1];
        neg_b   = sgn && b_ext[XLEN-1];
        mag_a   = neg_a ? -a_ext : a_ext;
        mag_b   = neg_b ? -b_ext : b_ext;
        // Word dividends are left-aligned so the first iteration sees bit 31
        a_start = is_word_op ? (mag_a << SHIFT) : mag_a;
        div0    = (b_ext == '0);
        ovf     = sgn && (a_ext == min_val) && (&b_ext);
    end

    // One restoring step: quotient bits shift in at the bottom of quo_q
    logic [XLEN:0]   rem_sh, diff;
    logic            fits;
    logic [XLEN-1:0] rem_n, quo_n;

    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, b_q};
        fits   = !diff[XLEN];
        rem_n  = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_n  = {quo_q[XLEN-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= DIV_S;
            word_q      <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            out_valid_q <= 1'b0;
            a_ext_q     <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            b_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= op;
                        word_q  <= is_word_op;
                        div0_q  <= div0;
                        ovf_q   <= ovf;
                        negq_q  <= neg_a ^ neg_b;
                        negr_q  <= neg_a;
                        a_ext_q <= a_ext;
                        quo_q   <= a_start;
                        rem_q   <= '0;
                        b_q     <= mag_b;
                        cnt_q   <= is_word_op ? CW'(32) : CW'(XLEN);
                        state_q <= CALC;
`ifdef DIV_EARLY_OUT_EN
                        if (div0 || ovf) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            y_q <= finalize(op, is_word_op, div0, ovf, 1'b0, 1'b0, a_ext, '0, '0);
                        end
`endif
                    end
                end
                CALC: begin
                    quo_q <= quo_n;
                    rem_q <= rem_n;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        y_q <= finalize(op_q, word_q, div0_q, ovf_q, negq_q, negr_q, a_ext_q, quo_n, rem_n);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_int_divider.sv
// tb/tb_int_divider.sv - directed self-checking bench for int_divider (XLEN=32 and XLEN=64 instances)
module tb_int_divider;
    import alu_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int SP32 = 1;
    localparam int SP64 = 1;
`else
    localparam int SP32 = 33;
    localparam int SP64 = 33;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid32 = 1'b0, in_valid64 = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] d0 = '0, d1 = '0;
    div_op_t     op = DIV_S;
    logic        is_word_op = 1'b0;
    logic        in_ready32, out_valid32, busy32;
    logic        in_ready64, out_valid64, busy64;
    logic [31:0] y32;
    logic [63:0] y64;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    int_divider #(.XLEN(32)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .d0(d0[31:0]), .d1(d1[31:0]), .op(op), .is_word_op(is_word_op),
        .out_valid(out_valid32), .out_ready(out_ready), .y(y32), .busy(busy32)
    );

    int_divider #(.XLEN(64)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .d0(d0), .d1(d1), .op(op), .is_word_op(is_word_op),
        .out_valid(out_valid64), .out_ready(out_ready), .y(y64), .busy(busy64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs_y(input bit sel64);
        return sel64 ? y64 : {32'h0, y32};
    endfunction

    function automatic logic obs_valid(input bit sel64);
        return sel64 ? out_valid64 : out_valid32;
    endfunction

    function automatic logic obs_ready(input bit sel64);
        return sel64 ? in_ready64 : in_ready32;
    endfunction

    task automatic issue(input bit sel64, input div_op_t o, input logic [63:0] a,
                         input logic [63:0] b, input bit w);
        @(negedge clk);
        op = o; d0 = a; d1 = b; is_word_op = w;
        if (sel64) in_valid64 = 1'b1; else in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        d0 = '1; d1 = '1;
    endtask

    // Issues an op, measures cycles from accept to out_valid, checks y, optionally completes the handshake
    task automatic run_op(input bit sel64, input div_op_t o, input logic [63:0] a, input logic [63:0] b,
                          input bit w, input int lat, input logic [63:0] ey, input string tag, input bit rel);
        int cyc;
        issue(sel64, o, a, b, w);
        cyc = 1;
        while (!obs_valid(sel64) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_y"}, obs_y(sel64), ey);
        check({tag, "_in_ready_low"}, 64'(obs_ready(sel64)), 64'd0);
        if (rel) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, "_valid_drop"}, 64'(obs_valid(sel64)), 64'd0);
            check({tag, "_in_ready_back"}, 64'(obs_ready(sel64)), 64'd1);
        end
    endtask

    initial begin
        bit   seen;
        logic [31:0] held;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_y", 64'(y32), 64'd0);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_in_ready", 64'(in_ready32), 64'd1);
        check("rst_y64", y64, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(0, DIV_S, 64'd100, 64'd7, 0, 33, 64'd14, "div_s_100_7", 1);
        run_op(0, REM_S, 64'd100, 64'd7, 0, 33, 64'd2, "rem_s_100_7", 1);
        run_op(0, REM_S, 64'hFFFF_FFF9, 64'd2, 0, 33, 64'hFFFF_FFFF, "rem_s_m7_2", 1);
        run_op(0, DIV_S, 64'hFFFF_FFF9, 64'd2, 0, 33, 64'hFFFF_FFFD, "div_s_m7_2", 1);
        run_op(0, DIV_U, 64'd5, 64'd0, 0, SP32, 64'hFFFF_FFFF, "div_u_by0", 1);
        run_op(0, REM_U, 64'd5, 64'd0, 0, SP32, 64'd5, "rem_u_by0", 1);
        run_op(0, DIV_S, 64'h8000_0000, 64'hFFFF_FFFF, 0, SP32, 64'h8000_0000, "div_s_ovf", 1);
        run_op(0, REM_S, 64'h8000_0000, 64'hFFFF_FFFF, 0, SP32, 64'd0, "rem_s_ovf", 1);
        run_op(0, DIV_U, 64'hFFFF_FFFF, 64'd16, 0, 33, 64'h0FFF_FFFF, "div_u_big", 1);

        run_op(1, DIV_S, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, SP64,
               64'hFFFF_FFFF_8000_0000, "w64_div_s_ovf", 1);
        run_op(1, DIV_U, 64'h0000_0000_FFFF_FFFF, 64'd1, 1, 33, 64'hFFFF_FFFF_FFFF_FFFF, "w64_div_u", 1);
        run_op(1, DIV_U, 64'd100, 64'd7, 0, 65, 64'd14, "x64_div_u", 1);
        run_op(1, REM_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 65, 64'hFFFF_FFFF_FFFF_FFFF, "x64_rem_s", 1);

        // Backpressure: result must hold while out_ready stays low
        run_op(0, DIV_U, 64'd1000, 64'd3, 0, 33, 64'd333, "hold", 0);
        held = y32;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid32), 64'd1);
            check("hold_y", 64'(y32), 64'(held));
            check("hold_in_ready", 64'(in_ready32), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_release_in_ready", 64'(in_ready32), 64'd1);
        check("hold_release_valid", 64'(out_valid32), 64'd0);

        // Reset during CALC cycle 15 discards the op
        issue(0, DIV_S, 64'd100, 64'd7, 0);
        repeat (14) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy32), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 64'(busy32), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready32), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid32) seen = 1'b1;
        end
        check("mid_rst_no_output", 64'(seen), 64'd0);
        run_op(0, DIV_S, 64'd100, 64'd7, 0, 33, 64'd14, "after_rst", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
